// File: rtl/ice_step_controller.sv
// Step sequencer for the ice_risc_rv core: single step, free run and run-to-breakpoint,
// producing a one-cycle step enable plus step count and state code for the debug display.
module ice_step_controller #(
  parameter int unsigned RUN_DIV   = 10000000,
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 iwClk,
  input  logic                 iwnRst,
  input  logic                 iwKey,
  input  logic [1:0]           iwMode,
  input  logic [31:0]          iwPc,
  input  logic [31:0]          iwBpAddr,
  output logic                 owStepEn,
  output logic                 owRunning,
  output logic                 owBpHit,
  output logic [CNT_WIDTH-1:0] owStepCount,
  output logic [1:0]           owState
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStep  = 2'b01,
    StRun   = 2'b10,
    StBreak = 2'b11
  } state_e;

  localparam logic [1:0] ModeStep  = 2'b00;
  localparam logic [1:0] ModeRun   = 2'b01;
  localparam logic [1:0] ModeBreak = 2'b10;
  localparam logic [1:0] ModeHalt  = 2'b11;

  localparam logic [DIV_WIDTH-1:0] DivLast = DIV_WIDTH'(RUN_DIV - 1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 skip_q, skip_d;
  logic                 step_en_q, step_en_d;
  logic                 key_prev_q;

  logic key_rise;
  logic mode_stop;
  logic bp_match;

  assign key_rise  = iwKey & ~key_prev_q;
  assign mode_stop = (iwMode == ModeStep) || (iwMode == ModeHalt);
  assign bp_match  = (iwMode == ModeBreak) && !skip_q && (iwPc == iwBpAddr);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    count_d   = count_q;
    skip_d    = skip_q;
    step_en_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_rise) begin
          if (iwMode == ModeStep) begin
            state_d = StStep;
          end else if ((iwMode == ModeRun) || (iwMode == ModeBreak)) begin
            state_d = StRun;
            div_d   = '0;
            skip_d  = 1'b1;
          end
        end
      end

      StStep: begin
        step_en_d = 1'b1;
        count_d   = count_q + CNT_WIDTH'(1);
        state_d   = StIdle;
      end

      StRun: begin
        if (key_rise || mode_stop) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (div_q == DivLast) begin
          div_d = '0;
          // Check happens before the pulse, so the breakpoint instruction has not run yet.
          if (bp_match) begin
            state_d = StBreak;
          end else begin
            step_en_d = 1'b1;
            count_d   = count_q + CNT_WIDTH'(1);
            skip_d    = 1'b0;
          end
        end else begin
          div_d = div_q + DIV_WIDTH'(1);
        end
      end

      StBreak: begin
        if (mode_stop) begin
          state_d = StIdle;
        end else if (key_rise) begin
          // Skip lets the first resumed step execute the instruction at the breakpoint.
          state_d = StRun;
          div_d   = '0;
          skip_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      count_q    <= '0;
      skip_q     <= 1'b0;
      step_en_q  <= 1'b0;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      count_q    <= count_d;
      skip_q     <= skip_d;
      step_en_q  <= step_en_d;
      key_prev_q <= iwKey;
    end
  end

  assign owStepEn    = step_en_q;
  assign owRunning   = (state_q == StRun);
  assign owBpHit     = (state_q == StBreak);
  assign owStepCount = count_q;
  assign owState     = state_q;

endmodule

// File: tb/tb_ice_step_controller.sv
// Directed bench for ice_step_controller: vector table for single-step, hand sequences for
// free run, breakpoint, counter wrap and mid-run reset.
module tb_ice_step_controller;

  logic        clk;
  logic        rst_n;
  logic        key;
  logic [1:0]  mode;
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        step_en;
  logic        running;
  logic        bp_hit;
  logic [3:0]  step_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  ice_step_controller #(
    .RUN_DIV  (4),
    .DIV_WIDTH(3),
    .CNT_WIDTH(4)
  ) dut (
    .iwClk      (clk),
    .iwnRst     (rst_n),
    .iwKey      (key),
    .iwMode     (mode),
    .iwPc       (pc),
    .iwBpAddr   (bp_addr),
    .owStepEn   (step_en),
    .owRunning  (running),
    .owBpHit    (bp_hit),
    .owStepCount(step_count),
    .owState    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       key;
    logic [1:0] mode;
    logic       exp_en;
    logic       exp_run;
    logic       exp_bp;
    logic [3:0] exp_cnt;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic k, logic [1:0] m, logic en, logic run, logic bp,
                              logic [3:0] cnt, logic [1:0] st);
    vec_t v;
    v.key = k; v.mode = m; v.exp_en = en; v.exp_run = run; v.exp_bp = bp;
    v.exp_cnt = cnt; v.exp_state = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_cnt;
  logic [31:0] exp_pc;
  int          pulses;
  int          gap;
  int          bad;

  initial begin
    rst_n   = 1'b0;
    key     = 1'b1;
    mode    = 2'b00;
    pc      = '0;
    bp_addr = '0;
    exp_cnt = '0;

    // Single-step table: key held through reset, one press, then three spaced presses.
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 4'd0, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 4'd0, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 4'd0, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 4'd0, 2'b01));
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 4'd1, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 4'd1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 4'd1, 2'b00));
    for (int p = 0; p < 3; p++) begin
      vecs.push_back(mk(1, 2'b00, 0, 0, 0, 4'(1 + p), 2'b01));
      vecs.push_back(mk(0, 2'b00, 1, 0, 0, 4'(2 + p), 2'b00));
      for (int j = 0; j < 8; j++) vecs.push_back(mk(0, 2'b00, 0, 0, 0, 4'(2 + p), 2'b00));
    end
    // Halt mode ignores the key.
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 4'd4, 2'b00));
    vecs.push_back(mk(0, 2'b11, 0, 0, 0, 4'd4, 2'b00));

    #12;
    chk("reset_outputs", {31'd0, step_en | running | bp_hit}, 32'd0);
    chk("reset_count", 32'(step_count), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      key  = vecs[i].key;
      mode = vecs[i].mode;
      tick();
      checks++;
      if ({step_en, running, bp_hit, step_count, state} !==
          {vecs[i].exp_en, vecs[i].exp_run, vecs[i].exp_bp, vecs[i].exp_cnt,
           vecs[i].exp_state}) begin
        errors++;
        $display("FAIL vec[%0d]: got en=%b run=%b bp=%b cnt=%0d st=%b, expected en=%b run=%b bp=%b cnt=%0d st=%b",
                 i, step_en, running, bp_hit, step_count, state, vecs[i].exp_en,
                 vecs[i].exp_run, vecs[i].exp_bp, vecs[i].exp_cnt, vecs[i].exp_state);
      end
    end
    exp_cnt = 4'd4;

    // Free run: pulse every 4 cycles, a second press stops it.
    mode = 2'b01;
    key  = 1'b1;
    tick();
    key = 1'b0;
    chk("run_enter_state", 32'(state), 32'h2);
    chk("run_enter_running", 32'(running), 32'd1);
    pulses = 0;
    gap    = 0;
    for (int c = 0; c < 40 && pulses < 5; c++) begin
      tick();
      gap++;
      if (step_en) begin
        pulses++;
        exp_cnt++;
        chk("run_pulse_gap", 32'(gap), 32'd4);
        chk("run_pulse_count", 32'(step_count), 32'(exp_cnt));
        gap = 0;
      end
    end
    chk("run_pulses_seen", 32'(pulses), 32'd5);
    key = 1'b1;
    tick();
    key = 1'b0;
    chk("run_stop_state", 32'(state), 32'h0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (step_en) bad++;
    end
    chk("run_stop_no_pulse", 32'(bad), 32'd0);
    chk("run_stop_count", 32'(step_count), 32'(exp_cnt));

    // Run to breakpoint at 0x10; bench core advances PC by 4 per pulse.
    mode    = 2'b10;
    bp_addr = 32'h10;
    pc      = 32'h0;
    key     = 1'b1;
    tick();
    key    = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60 && !bp_hit; c++) begin
      tick();
      if (step_en) begin
        exp_pc = 32'(pulses * 4);
        chk("bp_exec_pc", pc, exp_pc);
        pulses++;
        exp_cnt++;
        pc = pc + 32'd4;
      end
    end
    chk("bp_pulses_before", 32'(pulses), 32'd4);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_state", 32'(state), 32'h3);
    chk("bp_count", 32'(step_count), 32'(exp_cnt));
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (step_en || !bp_hit) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    key = 1'b1;
    tick();
    key = 1'b0;
    chk("bp_resume_state", 32'(state), 32'h2);
    chk("bp_resume_hit", 32'(bp_hit), 32'd0);
    pulses = 0;
    bad    = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bp_hit) bad++;
      if (step_en) begin
        if (pulses == 0) chk("bp_resume_pc", pc, 32'h10);
        pulses++;
        exp_cnt++;
        pc = pc + 32'd4;
      end
    end
    chk("bp_resume_pulses", 32'(pulses), 32'd3);
    chk("bp_no_rebreak", 32'(bad), 32'd0);
    mode = 2'b00;
    tick();
    chk("bp_exit_state", 32'(state), 32'h0);
    chk("bp_exit_count", 32'(step_count), 32'(exp_cnt));

    // Counter wrap after reset: 16 pulses bring a 4-bit count back to 0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrap_reset_count", 32'(step_count), 32'd0);
    #3;
    rst_n   = 1'b1;
    exp_cnt = '0;
    mode    = 2'b01;
    tick();
    key = 1'b1;
    tick();
    key    = 1'b0;
    pulses = 0;
    for (int c = 0; c < 100 && pulses < 16; c++) begin
      tick();
      if (step_en) begin
        pulses++;
        exp_cnt++;
        if (pulses == 15) chk("wrap_count_15", 32'(step_count), 32'd15);
      end
    end
    chk("wrap_pulses", 32'(pulses), 32'd16);
    chk("wrap_count_0", 32'(step_count), 32'(exp_cnt));

    // Reset between pulses takes effect without a clock edge.
    tick();
    tick();
    chk("midrst_running_before", 32'(running), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {29'd0, step_en, running, bp_hit}, 32'd0);
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_count", 32'(step_count), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bad   = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (step_en || state != 2'b00) bad++;
    end
    chk("midrst_idle_after", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ice_step_controller.md
Name: ice_step_controller

Overview:
- Sequences execution of the ice_risc_rv core on the board.
- Generates a one-cycle step enable for the core and its memory from a debounced key, or from an internal rate divider.
- Supports three execution modes: single step, free run, and run-to-breakpoint on a PC match.
- Exports a step count and a state code to the display mux for debugging.

Parameters:
- RUN_DIV, 10000000: iwClk cycles between steps in run modes; must be >= 2.
- DIV_WIDTH, 24: width of the rate divider; must satisfy 2^DIV_WIDTH > RUN_DIV.
- CNT_WIDTH, 16: width of the step counter.

Ports:
- iwClk  in  1  system clock; all state is on the rising edge.
- iwnRst  in  1  asynchronous, active-low reset.
- iwKey  in  1  debounced key level, synchronous to iwClk.
- iwMode  in  2  execution mode: 00 single step, 01 free run, 10 run to breakpoint, 11 halt.
- iwPc  in  32  current PC of the core.
- iwBpAddr  in  32  breakpoint PC.
- owStepEn  out  1  one-cycle step enable to the core and memory.
- owRunning  out  1  high while in state RUN.
- owBpHit  out  1  high while in state BREAK.
- owStepCount  out  CNT_WIDTH  number of owStepEn pulses issued.
- owState  out  2  00 IDLE, 01 STEP, 10 RUN, 11 BREAK.

Behaviour:
- Reset (asynchronous, immediate, also mid-run):
  - state IDLE.
  - owStepEn, owRunning, owBpHit = 0; owStepCount = 0.
  - Divider = 0, skip flag = 0.
  - rKeyPrev = 1, so a key held through reset release causes no edge.
- Key edge: KeyRise = iwKey & ~rKeyPrev; rKeyPrev <= iwKey every cycle.
- All outputs are registered.
- Every owStepEn pulse is exactly one cycle. owStepCount increments on the same edge that sets owStepEn; it wraps from all-ones to 0.
- IDLE:
  - mode 00 and KeyRise -> STEP.
  - mode 01 or 10 and KeyRise -> RUN, with divider = 0 and skip = 1.
  - mode 11: KeyRise is ignored.
- STEP:
  - owStepEn = 1 for this cycle only.
  - Next cycle -> IDLE unconditionally; KeyRise in this cycle is ignored.
  - Latency: KeyRise sampled at edge k; owStepEn high from edge k+1 to edge k+2.
- RUN:
  - Divider counts 0..RUN_DIV-1. At terminal count it reloads 0 and a step decision is made.
  - Step decision: if mode==10, skip==0 and iwPc==iwBpAddr -> BREAK with no pulse. Otherwise pulse owStepEn and clear skip.
  - Breakpoint is checked before the instruction at iwBpAddr executes.
  - Exit priority, highest first:
    - KeyRise -> IDLE, divider cleared, no pulse.
    - mode 00 or 11 -> IDLE, no pulse.
    - Terminal count -> step decision as above.
  - Mode change between 01 and 10 while running: stay in RUN; the check applies from the next terminal count.
- BREAK:
  - owBpHit = 1, no pulses.
  - KeyRise with mode 10 -> RUN, skip = 1, divider = 0, so execution resumes past the breakpoint instruction.
  - KeyRise with mode 01 -> RUN.
  - mode 00 or 11 -> IDLE; owBpHit clears on the transition.
- owRunning = (state==RUN); owState encodes the state as listed under Ports.
- iwPc and iwBpAddr are treated as stable between pulses; they are not synchronised here.

Test Plan (RUN_DIV=4 in bench):
- Reset with iwKey held high, release reset, mode 00 -> no owStepEn, count 0. Then release key, press once -> exactly one owStepEn pulse one cycle after the sampled rise; count 1; state back to IDLE.
- Mode 00, three presses separated by 10 cycles -> three pulses; count 3; owRunning never high.
- Mode 01, press -> pulses every 4 cycles. After 5 pulses, press again -> IDLE, no further pulse, count 5.
- Mode 10, iwBpAddr=0x10, bench model increments iwPc by 4 per pulse from 0:
  - Pulses at PC 0,4,8,0xC, then BREAK with owBpHit=1 and iwPc=0x10.
  - Press -> resumes; first pulse executes 0x10; no re-break.
- Count wrap: CNT_WIDTH=4, mode 01 -> after 16 pulses owStepCount = 0.
- Assert reset mid-RUN between pulses -> outputs 0 immediately; state IDLE; after release no pulse without a key press.
